// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus for the MEM stage
interface mem_stage_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemAck;
  logic [31:0] dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemAck, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemAck, dmemRdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX/MEM and MEM/WB registers, aligned single-outstanding data access
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_regWrite,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rdAddr,
  input  logic [31:0] i_aluOut,
  input  logic [31:0] i_rs2FwdOut,
  mem_stage_if.master dmem,
  output logic        o_stall,
  output logic [31:0] o_MEM_rd,
  output logic [4:0]  o_MEM_rdAddr,
  output logic        o_MEM_regWrite,
  output logic [31:0] o_WB_rd,
  output logic [4:0]  o_WB_rdAddr,
  output logic        o_WB_regWrite,
  output logic        o_misaligned,
  output logic        o_busErr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          exValid, exRead, exWrite, exRegWrite;
  logic [2:0]    exFunct3;
  logic [4:0]    exRdAddr;
  logic [31:0]   exAddr, exRs2;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   wbRd;
  logic [4:0]    wbRdAddr;
  logic          wbRegWrite, misPulse, busErrPulse;

  logic [1:0]    size, lo;
  logic          isMem, misaligned, needAccess, timeoutHit;
  logic [7:0]    ldByte;
  logic [15:0]   ldHalf;
  logic [31:0]   loadData, storeData;
  logic [3:0]    laneBe;

  assign size  = exFunct3[1:0];
  assign lo    = exAddr[1:0];
  assign isMem = exRead | exWrite;

  // size 10 and 11 are both word accesses, so size[1] alone selects word alignment
  assign misaligned = exValid & isMem &
                      (((size == 2'b01) & lo[0]) | (size[1] & (lo != 2'b00)));
  assign needAccess = exValid & isMem & !misaligned;
  assign timeoutHit = (state == REQ) && (cnt == CNT_LAST);

  assign dmem.dmemReq   = needAccess & !timeoutHit;
  assign dmem.dmemWe    = dmem.dmemReq & exWrite;
  assign dmem.dmemAddr  = {exAddr[31:2], 2'b00};
  assign dmem.dmemWdata = storeData;
  assign dmem.dmemBe    = dmem.dmemReq ? laneBe : 4'b0000;
  assign o_stall        = dmem.dmemReq & !dmem.dmemAck;

  always_comb begin
    ldByte = dmem.dmemRdata[7:0];
    case (lo)
      2'b01:   ldByte = dmem.dmemRdata[15:8];
      2'b10:   ldByte = dmem.dmemRdata[23:16];
      2'b11:   ldByte = dmem.dmemRdata[31:24];
      default: ldByte = dmem.dmemRdata[7:0];
    endcase
    ldHalf = lo[1] ? dmem.dmemRdata[31:16] : dmem.dmemRdata[15:0];
    case (size)
      2'b00:   loadData = {{24{!exFunct3[2] & ldByte[7]}}, ldByte};
      2'b01:   loadData = {{16{!exFunct3[2] & ldHalf[15]}}, ldHalf};
      default: loadData = dmem.dmemRdata;
    endcase
  end

  always_comb begin
    case (size)
      2'b00: begin
        storeData = {4{exRs2[7:0]}};
        laneBe    = 4'b0001 << lo;
      end
      2'b01: begin
        storeData = {2{exRs2[15:0]}};
        laneBe    = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = exRs2;
        laneBe    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exValid     <= 1'b0;
      exRead      <= 1'b0;
      exWrite     <= 1'b0;
      exRegWrite  <= 1'b0;
      exFunct3    <= 3'b000;
      exRdAddr    <= 5'd0;
      exAddr      <= 32'd0;
      exRs2       <= 32'd0;
      wbRd        <= 32'd0;
      wbRdAddr    <= 5'd0;
      wbRegWrite  <= 1'b0;
      misPulse    <= 1'b0;
      busErrPulse <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
    end else begin
      if (!o_stall) begin
        exValid    <= i_valid & !i_flush;
        exRead     <= i_memRead;
        exWrite    <= i_memWrite;
        exRegWrite <= i_regWrite;
        exFunct3   <= i_funct3;
        exRdAddr   <= i_rdAddr;
        exAddr     <= i_aluOut;
        exRs2      <= i_rs2FwdOut;
        wbRd       <= exRead ? loadData : exAddr;
        wbRdAddr   <= exRdAddr;
        wbRegWrite <= exValid & exRegWrite & !misaligned & !timeoutHit;
      end
      // pulses are computed outside the hold so they cannot stick high across a later stall
      misPulse    <= !o_stall & misaligned;
      busErrPulse <= timeoutHit;

      if (state == IDLE)
        state <= (dmem.dmemReq & !dmem.dmemAck) ? REQ : IDLE;
      else if (dmem.dmemAck | timeoutHit)
        state <= IDLE;

      if ((state == REQ) && !dmem.dmemAck && !timeoutHit)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

  assign o_MEM_rd       = exAddr;
  assign o_MEM_rdAddr   = exRdAddr;
  assign o_MEM_regWrite = exValid & exRegWrite;
  assign o_WB_rd        = wbRd;
  assign o_WB_rdAddr    = wbRdAddr;
  assign o_WB_regWrite  = wbRegWrite;
  assign o_misaligned   = misPulse;
  assign o_busErr       = busErrPulse;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage that consumes the execute stage's ALU result and forwarded rs2 value. It owns the EX/MEM and MEM/WB pipeline registers and drives a single-outstanding request/acknowledge data-memory port with byte-lane alignment. It also performs load extraction and sign extension, detects misaligned accesses, and stalls the upstream pipeline while an access is pending. It supplies the MEM-stage and WB-stage values used for register forwarding into execute.

Parameters:
TIMEOUT, 16, max cycles o_dmemReq may stay asserted without i_dmemAck before a bus error is flagged (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  EX-stage instruction valid
i_flush  in  1  kill the instruction entering MEM (branch/jump redirect)
i_memRead  in  1  instruction is a load
i_memWrite  in  1  instruction is a store
i_regWrite  in  1  instruction writes rd
i_funct3  in  3  load/store size/sign code
i_rdAddr  in  5  destination register
i_aluOut  in  32  ALU result / effective address
i_rs2FwdOut  in  32  store data (already forwarded)
i_dmemAck  in  1  data memory accepted/completed the request this cycle
i_dmemRdata  in  32  read word, valid with i_dmemAck
o_dmemReq  out  1  access request
o_dmemWe  out  1  write enable
o_dmemAddr  out  32  word address (bits [1:0] forced 0)
o_dmemWdata  out  32  lane-replicated store data
o_dmemBe  out  4  byte enables
o_stall  out  1  hold EX and earlier stages
o_MEM_rd  out  32  EX/MEM registered ALU result (forwarding source)
o_MEM_rdAddr  out  5  EX/MEM rd, for the hazard unit
o_MEM_regWrite  out  1  EX/MEM regWrite & valid
o_WB_rd  out  32  MEM/WB result (load data or ALU result)
o_WB_rdAddr  out  5  MEM/WB rd
o_WB_regWrite  out  1  MEM/WB writeback enable
o_misaligned  out  1  one-cycle pulse: misaligned access retired
o_busErr  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset: all pipeline registers invalid/zero, FSM to IDLE, timeout counter 0. All outputs are 0 the cycle after reset is sampled, and stay 0 while reset is held. A reset asserted mid-access abandons the access; o_dmemReq is 0 in the following cycle.
- EX/MEM register loads on each edge where !o_stall. The loaded valid bit is i_valid & !i_flush. If o_stall=1, the register holds and i_flush is ignored.
- Misalignment, computed from the EX/MEM register:
  - halfword (funct3[1:0]=01) with addr[0]=1
  - word (funct3[1:0]=10) with addr[1:0]!=0
  - byte accesses are never misaligned
  - funct3 values 011, 110 and 111 are treated as word accesses.
- FSM IDLE/REQ:
  - IDLE: when the EX/MEM entry is valid, is a memory op and is aligned, o_dmemReq=1 combinationally this cycle, and the FSM enters REQ unless i_dmemAck arrives the same cycle.
  - REQ: o_dmemReq stays 1 with stable address/data/BE until i_dmemAck, then returns to IDLE.
- Request, ack and stall:
  - Zero-wait ack means one cycle per access with no stall.
  - o_stall = o_dmemReq & !i_dmemAck & !timeout.
- Timeout counter: counts cycles with o_dmemReq & !i_dmemAck; clears on ack or IDLE. When it reaches TIMEOUT-1 in REQ:
  - that cycle, o_dmemReq drops and o_stall=0;
  - the next edge pulses o_busErr and writes back with o_WB_regWrite=0.
- Store lanes:
  - SB: byte replicated to all lanes, BE = 1<<addr[1:0]
  - SH: halfword replicated, BE 0011 (addr[1]=0) or 1100
  - SW: BE 1111
  - o_dmemWe = memWrite.
- Load extraction from i_dmemRdata using addr[1:0]:
  - LB/LH sign-extend
  - LBU/LHU zero-extend
  - LW passes the word through.
- MEM/WB register loads on each edge where !o_stall.
  - o_WB_rd = extracted load data for loads, else o_MEM_rd.
  - o_WB_regWrite = valid & regWrite & !misaligned & !busErr.
  - A misaligned access issues no request, retires in one cycle, pulses o_misaligned and suppresses writeback.
  - A stall inserts no bubble: MEM/WB holds its previous contents.
- Latency:
  - Non-memory op: EX->MEM at edge N, WB at edge N+1.
  - Load acked k cycles after entering MEM: WB at edge N+1+k.
- Back-to-back memory ops: the next request is issued in the cycle immediately after the ack edge, with no idle cycle.

Test Plan:
- Reset with i_valid=1, i_memRead=1, i_aluOut=0x100 held across reset -> all outputs 0 while reset held; first request addr 0x100 one cycle after release.
- SB at addr 0x1003, rs2=0x000000A5, ack same cycle -> o_dmemAddr=0x1000, Wdata=0xA5A5A5A5, BE=1000, o_stall=0, o_WB_regWrite=0.
- LB at 0x2001, ack after 3 wait cycles, rdata=0x00008000 -> o_stall high exactly 3 cycles; o_WB_rd=0xFFFFFF80 then. Repeat as LBU -> 0x00000080.
- LW at 0x3002 -> no o_dmemReq, o_misaligned pulses once, o_WB_regWrite=0, no stall.
- TIMEOUT=4, load never acked -> o_dmemReq high 4 cycles, o_busErr pulses once, pipeline resumes, o_WB_regWrite=0.
- ADD result 0x1234 (rd=5) with i_flush=1 during a stall vs. not stalled -> ignored while stalled; when not stalled the entry becomes a bubble (o_MEM_regWrite=0, no WB).
